booth_mul32: RTL and testbench

BOOTH_MUL32 -- requirements
Module: booth_mul32

---
 rtl/booth_mul32.sv | 80 ++++++++
 tb/tb_booth_mul32.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul32.sv
// Radix-2 Booth sequential multiplier, 32x32 signed -> 64-bit product.
// One Booth iteration per EXEC cycle; 32 cycles from accepted start to DONE.
module booth_mul32 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_start,
    input  logic        op_clear,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        op_done,
    output logic [63:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [32:0] r_acc;
    logic [31:0] r_q;
    logic        r_q1;
    logic [32:0] r_m;
    logic [4:0]  r_cnt;

    logic [32:0] w_sum;
    logic        w_start;

    // 33-bit ACC absorbs the -2^31 x -2^31 corner without overflow.
    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_acc + r_m;
            2'b10:   w_sum = r_acc - r_m;
            default: w_sum = r_acc;
        endcase
    end

    assign w_start = op_start && !op_clear &&
                     ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_m     <= '0;
            r_cnt   <= '0;
        end else if (op_clear) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_m     <= '0;
            r_cnt   <= '0;
        end else if (w_start) begin
            r_state <= S_EXEC;
            r_acc   <= '0;
            r_q     <= multiplier;
            r_q1    <= 1'b0;
            r_m     <= {multiplicand[31], multiplicand};
            r_cnt   <= '0;
        end else if (r_state == S_EXEC) begin
            // Arithmetic shift of {ACC,Q,Q_1} applied to the post-add ACC.
            r_acc <= {w_sum[32], w_sum[32:1]};
            r_q   <= {w_sum[0], r_q[31:1]};
            r_q1  <= r_q[0];
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_state <= S_DONE;
            end
        end else if (r_state == 2'd3) begin
            r_state <= S_IDLE;
        end
    end

    assign op_done = (r_state == S_DONE);
    assign result  = {r_acc[31:0], r_q};

endmodule

// File: tb/tb_booth_mul32.sv
// Self-checking bench for booth_mul32: directed corner cases plus random
// signed operands against a 64-bit arithmetic reference.
module tb_booth_mul32;

    logic        clk;
    logic        reset_n;
    logic        op_start;
    logic        op_clear;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        op_done;
    logic [63:0] result;

    int unsigned n_checks;
    int unsigned n_errors;

    booth_mul32 dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .op_done      (op_done),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
        logic signed [63:0] a;
        logic signed [63:0] b;
        a = $signed(m);
        b = $signed(q);
        return a * b;
    endfunction

    task automatic start_op(input logic [31:0] m, input logic [31:0] q);
        @(negedge clk);
        op_start     = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(posedge clk);
        #1;
        op_start     = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    // Counts edges after the current point until op_done, bounded at 40.
    task automatic wait_done(output int unsigned cyc);
        cyc = 0;
        while (!op_done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] m, input logic [31:0] q,
                           input logic chk_lat);
        int unsigned cyc;
        start_op(m, q);
        wait_done(cyc);
        if (chk_lat) check({tag, "_lat"}, 64'(cyc), 64'd32);
        check(tag, result, ref_mul(m, q));
    endtask

    task automatic watch_no_done(input string tag, input int unsigned n);
        logic seen;
        seen = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (op_done) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int unsigned cyc;
        n_checks     = 0;
        n_errors     = 0;
        reset_n      = 1'b0;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1;
        check("rst_result", result, 64'd0);
        check("rst_done", 64'(op_done), 64'd0);
        #20;
        @(negedge clk);
        reset_n = 1'b1;
        watch_no_done("idle_hold", 5);

        run_one("m3q5", 32'd3, 32'd5, 1'b1);
        check("m3q5_const", result, 64'h0000_0000_0000_000F);
        run_one("m7qm3", 32'd7, 32'hFFFF_FFFD, 1'b1);
        check("m7qm3_const", result, 64'hFFFF_FFFF_FFFF_FFEB);
        run_one("mm1qm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("mm1qm1_const", result, 64'h0000_0000_0000_0001);
        run_one("minmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
        check("minmin_const", result, 64'h4000_0000_0000_0000);
        run_one("minx1", 32'h8000_0000, 32'd1, 1'b1);
        check("minx1_const", result, 64'hFFFF_FFFF_8000_0000);

        // Start ignored while executing.
        start_op(32'd3, 32'd5);
        for (int unsigned i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        op_start     = 1'b1;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        wait_done(cyc);
        check("ign_lat", 64'(cyc + 10), 64'd32);
        check("ign_result", result, 64'd15);
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("done_hold", 64'(op_done), 64'd1);
        check("done_hold_res", result, 64'd15);
        start_op(32'd9, 32'd9);
        check("restart_drop", 64'(op_done), 64'd0);
        wait_done(cyc);
        check("restart_lat", 64'(cyc + 1), 64'd33);
        check("restart_res", result, 64'h51);

        // Clear has priority over start.
        start_op(32'd3, 32'd5);
        for (int unsigned i = 1; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        op_clear = 1'b1;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_clear = 1'b0;
        op_start = 1'b0;
        check("clr_result", result, 64'd0);
        check("clr_done", 64'(op_done), 64'd0);
        watch_no_done("clr_nodone", 40);
        check("clr_result2", result, 64'd0);

        // Asynchronous reset mid-operation.
        start_op(32'h1234_5678, 32'h7654_3210);
        for (int unsigned i = 1; i < 20; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_result", result, 64'd0);
        check("arst_done", 64'(op_done), 64'd0);
        #30;
        @(negedge clk);
        reset_n = 1'b1;
        watch_no_done("arst_nodone", 40);
        check("arst_result2", result, 64'd0);

        // First edge after reset release accepts a start.
        @(negedge clk);
        reset_n = 1'b0;
        #10;
        @(negedge clk);
        reset_n      = 1'b1;
        op_start     = 1'b1;
        multiplicand = 32'hFFFF_FFF9;
        multiplier   = 32'd6;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        wait_done(cyc);
        check("rel_lat", 64'(cyc), 64'd32);
        check("rel_res", result, ref_mul(32'hFFFF_FFF9, 32'd6));

        for (int unsigned i = 0; i < 1000; i++) begin
            logic [31:0] m;
            logic [31:0] q;
            m = $urandom;
            q = $urandom;
            run_one("rand", m, q, (i % 50) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
